// File: rtl/vex_rdc_unit.sv
// Pipelined vector reduction: masked lane input register, log2(LANES) tree
// levels, then an accumulate/writeback stage for multi-uop reductions.
module vex_rdc_unit #(
  parameter int VECTOR_LANES       = 8,
  parameter int DATA_WIDTH         = 32,
  parameter int VECTOR_REGISTERS   = 32,
  parameter int VECTOR_TICKET_BITS = 5
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                valid_i,
  output logic                                ready_o,
  input  logic [2:0]                          op_i,
  input  logic [VECTOR_LANES-1:0]             mask_i,
  input  logic [VECTOR_LANES*DATA_WIDTH-1:0]  data_i,
  input  logic [DATA_WIDTH-1:0]               scalar_i,
  input  logic                                head_uop_i,
  input  logic                                end_uop_i,
  input  logic [$clog2(VECTOR_REGISTERS)-1:0] dst_i,
  input  logic [VECTOR_TICKET_BITS-1:0]       ticket_i,
  output logic                                wr_valid_o,
  input  logic                                wr_ready_i,
  output logic [$clog2(VECTOR_REGISTERS)-1:0] wr_addr_o,
  output logic [DATA_WIDTH-1:0]               wr_data_o,
  output logic [VECTOR_TICKET_BITS-1:0]       wr_ticket_o,
  output logic                                idle_o
);

  localparam int L     = VECTOR_LANES;
  localparam int S     = $clog2(VECTOR_LANES);
  localparam int DW    = DATA_WIDTH;
  localparam int AW    = $clog2(VECTOR_REGISTERS);
  localparam int TW    = VECTOR_TICKET_BITS;
  localparam int NODES = 2 * L - 1;

  typedef struct packed {
    logic          valid;
    logic [2:0]    op;
    logic          head;
    logic          last;
    logic [AW-1:0] dst;
    logic [TW-1:0] ticket;
    logic [DW-1:0] scalar;
  } meta_t;

  function automatic logic [DW-1:0] op_fn(
    input logic [2:0]    op,
    input logic [DW-1:0] a,
    input logic [DW-1:0] b
  );
    logic [DW-1:0] r;
    r = '0;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a & b;
      3'd2: r = a | b;
      3'd3: r = a ^ b;
      3'd4: r = (a < b) ? a : b;
      3'd5: r = ($signed(a) < $signed(b)) ? a : b;
      3'd6: r = (a > b) ? a : b;
      3'd7: r = ($signed(a) > $signed(b)) ? a : b;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [DW-1:0] ident(input logic [2:0] op);
    logic [DW-1:0] r;
    r = '0;
    case (op)
      3'd1, 3'd4: r = '1;
      3'd5:       r = {1'b0, {(DW-1){1'b1}}};
      3'd7:       r = {1'b1, {(DW-1){1'b0}}};
      default:    r = '0;
    endcase
    return r;
  endfunction

  meta_t         m  [S+1];
  logic [DW-1:0] nd [NODES];
  logic [DW-1:0] acc;
  logic          acc_open;
  logic          adv;
  logic          busy;
  logic [DW-1:0] base;
  logic [DW-1:0] res;

  assign adv     = ~wr_valid_o | wr_ready_i;
  assign ready_o = adv;

  // nd holds every tree level back to back: level s starts at 2L-2(L>>s)
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= S; i++) m[i] <= '0;
      for (int i = 0; i < NODES; i++) nd[i] <= '0;
    end else if (adv) begin
      m[0] <= {valid_i, op_i, head_uop_i, end_uop_i,
               dst_i, ticket_i, scalar_i};
      for (int s = 1; s <= S; s++) m[s] <= m[s-1];
      for (int k = 0; k < L; k++)
        nd[k] <= mask_i[k] ? data_i[k*DW +: DW] : ident(op_i);
      for (int s = 1; s <= S; s++)
        for (int j = 0; j < (L >> s); j++)
          nd[2*L - 2*(L >> s) + j] <=
            op_fn(m[s-1].op,
                  nd[2*L - 2*(L >> (s-1)) + 2*j],
                  nd[2*L - 2*(L >> (s-1)) + 2*j + 1]);
    end
  end

  assign base = (m[S].head | ~acc_open) ? m[S].scalar : acc;
  assign res  = op_fn(m[S].op, base, nd[NODES-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      acc_open    <= 1'b0;
      wr_valid_o  <= 1'b0;
      wr_addr_o   <= '0;
      wr_data_o   <= '0;
      wr_ticket_o <= '0;
    end else if (adv) begin
      wr_valid_o <= m[S].valid & m[S].last;
      if (m[S].valid) begin
        acc      <= res;
        acc_open <= ~m[S].last;
        if (m[S].last) begin
          wr_addr_o   <= m[S].dst;
          wr_data_o   <= res;
          wr_ticket_o <= m[S].ticket;
        end
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i <= S; i++) busy = busy | m[i].valid;
  end

  assign idle_o = ~busy & ~acc_open & ~wr_valid_o;

endmodule
